// File: rtl/i2c_txn_seq.sv
// Transaction sequencer in front of the I2C master: command intake, TX FIFO,
// master handshake (enable / data_valid / read_last) and per-transaction status.
//
// state  | meaning
// IDLE   | waiting for a command; cmd_ready follows m_ready
// LAUNCH | m_i2c_en held until the master drops ready
// BUSY   | master on the bus; feed write bytes / collect read bytes
// FLUSH  | discard write bytes the master never took
// FINISH | one-cycle done pulse with status
module i2c_txn_seq #(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 5,
  parameter int I2C_DIV    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_addr,
  input  logic             cmd_rw,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             tx_wr_en,
  input  logic [7:0]       tx_wr_data,
  output logic             tx_full,
  output logic             tx_ovf,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             done,
  output logic             done_err,
  output logic [LEN_W-1:0] done_cnt,
  output logic [6:0]       m_addr,
  output logic             m_rw,
  output logic [7:0]       m_tx_data,
  output logic             m_i2c_en,
  output logic             m_data_valid,
  output logic             m_read_last,
  input  logic             m_data_next,
  input  logic [7:0]       m_rx_data,
  input  logic             m_ready
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int BUSY_MAX = 16 * I2C_DIV;
  localparam int TMR_W    = $clog2(BUSY_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_BUSY, S_FLUSH, S_FINISH} state_t;

  state_t state, state_nxt;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             push, pop, pop_req;

  logic [LEN_W-1:0] len_q, sent, rd_cnt, cnt_q;
  logic [TMR_W-1:0] busy_tmr;
  logic             err_q;
  logic             m_ready_d, m_data_next_d;
  logic             next_rise, rdy_fall, rdy_rise;
  logic             cmd_fire, reject, addr_nack;

  assign next_rise = m_data_next && !m_data_next_d;
  assign rdy_fall  = !m_ready && m_ready_d;
  assign rdy_rise  = m_ready && !m_ready_d;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign reject    = (cmd_len == '0) || (!cmd_rw && (int'(fifo_cnt) < int'(cmd_len)));
  // Timer still running at ready-rise means the master gave up during the address byte.
  assign addr_nack = (busy_tmr != '0);

  // TX FIFO
  assign tx_full   = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign push      = tx_wr_en && !tx_full;
  assign pop       = pop_req && (fifo_cnt != '0);
  assign m_tx_data = (fifo_cnt != '0) ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      tx_ovf   <= 1'b0;
    end else begin
      tx_ovf <= tx_wr_en && tx_full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cmd_fire) state_nxt = reject ? S_FINISH : S_LAUNCH;
      S_LAUNCH: if (rdy_fall) state_nxt = S_BUSY;
      S_BUSY:
        if (rdy_rise)
          state_nxt = (!m_rw && (addr_nack || (sent < len_q))) ? S_FLUSH : S_FINISH;
      S_FLUSH:  if (int'(sent) + 1 >= int'(len_q)) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_ready    = 1'b0;
    m_i2c_en     = 1'b0;
    m_data_valid = 1'b0;
    m_read_last  = 1'b0;
    done         = 1'b0;
    done_err     = 1'b0;
    done_cnt     = '0;
    pop_req      = 1'b0;
    case (state)
      S_IDLE:   cmd_ready = m_ready;
      S_LAUNCH: begin
        m_i2c_en = 1'b1;
        pop_req  = rdy_fall && !m_rw;
      end
      S_BUSY: begin
        m_data_valid = !m_rw && (sent < len_q);
        m_read_last  = m_rw && (rd_cnt == len_q - 1'b1);
        pop_req      = !m_rw && next_rise && (sent < len_q);
      end
      S_FLUSH:  pop_req = (sent < len_q);
      S_FINISH: begin
        done     = 1'b1;
        done_err = err_q;
        done_cnt = cnt_q;
      end
      default: ;
    endcase
  end

  // Transaction datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      m_addr        <= '0;
      m_rw          <= 1'b0;
      len_q         <= '0;
      sent          <= '0;
      rd_cnt        <= '0;
      busy_tmr      <= '0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      m_ready_d     <= 1'b1;
      m_data_next_d <= 1'b0;
    end else begin
      m_ready_d     <= m_ready;
      m_data_next_d <= m_data_next;
      rx_valid      <= 1'b0;
      case (state)
        S_IDLE:
          if (cmd_fire) begin
            m_addr   <= cmd_addr;
            m_rw     <= cmd_rw;
            len_q    <= cmd_len;
            sent     <= '0;
            rd_cnt   <= '0;
            busy_tmr <= TMR_W'(BUSY_MAX);
            if (reject) begin
              err_q <= 1'b1;
              cnt_q <= '0;
            end
          end
        S_LAUNCH:
          if (rdy_fall && !m_rw) sent <= LEN_W'(1);
        S_BUSY: begin
          if (busy_tmr != '0) busy_tmr <= busy_tmr - 1'b1;
          if (next_rise) begin
            if (!m_rw && (sent < len_q)) sent <= sent + 1'b1;
            if (m_rw) begin
              rx_valid <= 1'b1;
              rx_data  <= m_rx_data;
              rd_cnt   <= rd_cnt + 1'b1;
            end
          end
          if (rdy_rise) begin
            if (addr_nack) begin
              err_q <= 1'b1;
              cnt_q <= '0;
            end else if (!m_rw && (sent < len_q)) begin
              err_q <= 1'b1;
              cnt_q <= sent;
            end else begin
              err_q <= 1'b0;
              cnt_q <= len_q;
              // the last read byte has no data_next; it arrives with ready
              if (m_rw) begin
                rx_valid <= 1'b1;
                rx_data  <= m_rx_data;
              end
            end
          end
        end
        S_FLUSH:
          if (sent < len_q) sent <= sent + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_seq.sv
// Bench for i2c_txn_seq: drives a behavioural I2C master and checks against a
// queue model of the TX FIFO and the transaction status rules.
module tb_i2c_txn_seq;
  localparam int FIFO_DEPTH = 16;
  localparam int LEN_W      = 5;
  localparam int I2C_DIV    = 4;
  localparam int BYTE_CYC   = 9 * I2C_DIV;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, cmd_rw, tx_wr_en, tx_full, tx_ovf;
  logic [6:0] cmd_addr, m_addr;
  logic [LEN_W-1:0] cmd_len, done_cnt;
  logic [7:0] tx_wr_data, rx_data, m_tx_data, m_rx_data;
  logic rx_valid, done, done_err, m_rw, m_i2c_en, m_data_valid, m_read_last;
  logic m_data_next, m_ready;

  always #5 clk = ~clk;

  i2c_txn_seq #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W), .I2C_DIV(I2C_DIV)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_len(cmd_len),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_ovf(tx_ovf),
    .rx_valid(rx_valid), .rx_data(rx_data), .done(done), .done_err(done_err),
    .done_cnt(done_cnt), .m_addr(m_addr), .m_rw(m_rw), .m_tx_data(m_tx_data),
    .m_i2c_en(m_i2c_en), .m_data_valid(m_data_valid), .m_read_last(m_read_last),
    .m_data_next(m_data_next), .m_rx_data(m_rx_data), .m_ready(m_ready)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] model_q[$];
  logic [7:0] bus_got[$];
  logic [7:0] rx_got[$];
  int done_pulses;
  logic done_err_got;
  logic [LEN_W-1:0] done_cnt_got;
  logic en_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rx_valid) rx_got.push_back(rx_data);
    if (done) begin
      done_pulses++;
      done_err_got = done_err;
      done_cnt_got = done_cnt;
    end
    if (m_i2c_en) en_seen = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic exp_ovf;
    exp_ovf = (model_q.size() == FIFO_DEPTH);
    tx_wr_en = 1'b1; tx_wr_data = b;
    tick();
    tx_wr_en = 1'b0;
    chk("tx_ovf", tx_ovf, exp_ovf);
    if (!exp_ovf) model_q.push_back(b);
  endtask

  task automatic send_cmd(input logic [6:0] addr, input logic rw, input int len);
    bus_got.delete(); rx_got.delete(); done_pulses = 0; en_seen = 1'b0;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_rw = rw; cmd_len = LEN_W'(len);
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
    chk("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_en();
    for (int i = 0; i < 10 && !m_i2c_en; i++) tick();
    chk("i2c_en", m_i2c_en, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 64 && done_pulses == 0; i++) tick();
    tick();
    chk("done_once", done_pulses, 1);
  endtask

  // nack_at: -1 all acked, 0 address NACK, k NACK on data byte k
  task automatic master_write(input int nack_at);
    logic dv;
    logic [7:0] d;
    wait_en();
    if (nack_at != 0) bus_got.push_back(m_tx_data);
    m_ready = 1'b0;
    if (nack_at == 0) begin
      repeat (20) tick();
      m_ready = 1'b1;
      return;
    end
    repeat (BYTE_CYC) tick();
    for (int k = 1; k <= FIFO_DEPTH + 1; k++) begin
      repeat (BYTE_CYC) tick();
      if (nack_at == k) break;
      dv = m_data_valid; d = m_tx_data;
      m_data_next = 1'b1; tick(); tick(); m_data_next = 1'b0;
      if (!dv) break;
      bus_got.push_back(d);
    end
    repeat (4) tick();
    m_ready = 1'b1;
  endtask

  task automatic master_read(input logic [7:0] data[$], input logic nack, input int len);
    wait_en();
    m_ready = 1'b0;
    if (nack) begin
      repeat (20) tick();
      m_ready = 1'b1;
      return;
    end
    repeat (BYTE_CYC) tick();
    for (int i = 0; i < len - 1; i++) begin
      repeat (BYTE_CYC) tick();
      chk("read_last_mid", m_read_last, 0);
      m_rx_data = data[i];
      m_data_next = 1'b1; tick(); tick(); m_data_next = 1'b0;
    end
    repeat (BYTE_CYC) tick();
    chk("read_last_end", m_read_last, 1);
    m_rx_data = data[len-1];
    m_ready = 1'b1;
  endtask

  task automatic run_write(input logic [6:0] addr, input int len, input int nack_at);
    logic [7:0] exp_b[$];
    int n_bus, latched;
    logic exp_err;
    if (nack_at == 0)     begin n_bus = 0;       latched = 1;       end
    else if (nack_at > 0) begin n_bus = nack_at; latched = nack_at; end
    else                  begin n_bus = len;     latched = len;     end
    exp_err = (nack_at == 0) || (nack_at > 0 && nack_at < len);
    for (int i = 0; i < n_bus; i++) exp_b.push_back(model_q[i]);
    send_cmd(addr, 1'b0, len);
    chk("m_addr", m_addr, addr);
    chk("m_rw", m_rw, 0);
    master_write(nack_at);
    chk("dv_end", m_data_valid, latched < len);
    wait_done();
    chk("wr_err", done_err_got, exp_err);
    chk("wr_cnt", done_cnt_got, n_bus);
    chk("bus_len", bus_got.size(), exp_b.size());
    for (int i = 0; i < exp_b.size(); i++)
      chk("bus_byte", (i < bus_got.size()) ? {56'd0, bus_got[i]} : 64'hDEAD, exp_b[i]);
    repeat (len) void'(model_q.pop_front());
    chk("fifo_head", m_tx_data, (model_q.size() != 0) ? model_q[0] : 8'h00);
  endtask

  task automatic run_read(input logic [6:0] addr, input logic [7:0] data[$], input logic nack);
    int len;
    len = data.size();
    send_cmd(addr, 1'b1, len);
    chk("m_addr", m_addr, addr);
    chk("m_rw", m_rw, 1);
    master_read(data, nack, len);
    wait_done();
    chk("rd_err", done_err_got, nack);
    chk("rd_cnt", done_cnt_got, nack ? 0 : len);
    chk("rx_len", rx_got.size(), nack ? 0 : len);
    if (!nack)
      for (int i = 0; i < len; i++)
        chk("rx_byte", (i < rx_got.size()) ? {56'd0, rx_got[i]} : 64'hDEAD, data[i]);
  endtask

  task automatic run_reject(input logic rw, input int len);
    send_cmd(7'h22, rw, len);
    if (done_pulses == 0) tick();
    chk("rej_fast", done_pulses, 1);
    tick();
    chk("rej_once", done_pulses, 1);
    chk("rej_err", done_err_got, 1);
    chk("rej_cnt", done_cnt_got, 0);
    chk("rej_no_en", en_seen, 0);
    chk("rej_head", m_tx_data, (model_q.size() != 0) ? model_q[0] : 8'h00);
  endtask

  initial begin
    logic [7:0] rd[$];
    int len, mode, nack_at;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0; cmd_len = '0;
    tx_wr_en = 1'b0; tx_wr_data = '0; m_data_next = 1'b0; m_rx_data = '0; m_ready = 1'b1;
    done_pulses = 0; en_seen = 1'b0; done_err_got = 1'b0; done_cnt_got = '0;
    repeat (3) tick();
    chk("rst_outs", {done, done_err, done_cnt, rx_valid, rx_data, m_i2c_en, m_data_valid,
                     m_read_last, m_addr, m_rw, m_tx_data, tx_full, tx_ovf}, 0);
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);

    push_byte(8'hA5); push_byte(8'h3C); push_byte(8'hFF);
    run_write(7'h50, 3, -1);

    rd = '{8'h12, 8'h34};
    run_read(7'h51, rd, 1'b0);

    push_byte(8'($urandom)); push_byte(8'($urandom));
    run_write(7'h28, 2, 0);

    push_byte(8'($urandom)); push_byte(8'($urandom));
    run_reject(1'b0, 4);
    run_reject(1'b1, 0);

    rd = '{8'($urandom)};
    run_read(7'h3A, rd, 1'b0);
    run_read(7'h3A, rd, 1'b1);

    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 5);
      mode = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        rd.delete();
        for (int i = 0; i < len; i++) rd.push_back(8'($urandom));
        run_read(7'($urandom), rd, mode == 0);
      end else begin
        for (int i = 0; i < len; i++) push_byte(8'($urandom));
        nack_at = (mode == 0) ? 0 : (mode == 1) ? $urandom_range(1, len) : -1;
        run_write(7'($urandom), len, nack_at);
      end
    end

    while (model_q.size() < FIFO_DEPTH) push_byte(8'($urandom));
    push_byte(8'hEE);
    chk("tx_full", tx_full, 1);
    tick();
    chk("ovf_pulse", tx_ovf, 0);

    send_cmd(7'h33, 1'b1, 3);
    wait_en();
    m_ready = 1'b0;
    repeat (40) tick();
    m_rx_data = 8'h5A;
    m_data_next = 1'b1; tick(); tick(); m_data_next = 1'b0;
    chk("pre_rst_rx", rx_got.size(), 1);
    rst = 1'b1;
    tick();
    chk("midrst_outs", {done, done_err, done_cnt, rx_valid, rx_data, m_i2c_en, m_data_valid,
                        m_read_last, m_addr, m_rw, m_tx_data, tx_full, tx_ovf, cmd_ready}, 0);
    model_q.delete();
    rst = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("post_rst_ready", cmd_ready, 1);
    push_byte(8'h81); push_byte(8'h7E);
    run_write(7'h10, 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
